axi_chan_fifo_slice: RTL
========================

Name: axi_chan_fifo_slice

Overview:
- Parametrised AXI4+ATOP buffering slice: one independent, configurable-depth FIFO per channel (AW, W, B, AR, R).
- Sits between an upstream manager port (s_*) and a downstream subordinate port (m_*). Used in crossbar test harnesses and on DUT-side paths to decouple timing and inject backpressure depth.
- Successor to the plain channel bundle: adds per-channel depth, ready/valid buffering, pass-through mode and optional occupancy statistics.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; multiple of 8; STRB_W = DATA_W/8
- ID_W, 4, transaction ID width
- USER_W, 1, user width; minimum 1
- AW_DEPTH, 2, AW FIFO entries; 0 = combinational pass-through
- W_DEPTH, 4, W FIFO entries; 0 = pass-through
- B_DEPTH, 2, B FIFO entries; 0 = pass-through
- AR_DEPTH, 2, AR FIFO entries; 0 = pass-through
- R_DEPTH, 4, R FIFO entries; 0 = pass-through

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- s_aw_valid/s_aw_ready  in/out  1  upstream AW handshake
- s_aw_pld  in  ID_W+ADDR_W+USER_W+35  {id,addr,len8,size3,burst2,lock,cache4,prot3,qos4,region4,atop6,user}
- m_aw_valid/m_aw_ready  out/in  1  downstream AW handshake
- m_aw_pld  out  same as s_aw_pld  downstream AW payload
- s_w_valid/s_w_ready, m_w_valid/m_w_ready  1 each  W handshakes
- s_w_pld/m_w_pld  in/out  DATA_W+STRB_W+1+USER_W  {data,strb,last,user}
- m_b_valid/m_b_ready, s_b_valid/s_b_ready  1 each  B handshakes (B flows m→s)
- m_b_pld/s_b_pld  in/out  ID_W+2+USER_W  {id,resp,user}
- s_ar_valid/s_ar_ready, m_ar_valid/m_ar_ready  1 each  AR handshakes
- s_ar_pld/m_ar_pld  in/out  ID_W+ADDR_W+USER_W+29  AW layout without atop
- m_r_valid/m_r_ready, s_r_valid/s_r_ready  1 each  R handshakes (R flows m→s)
- m_r_pld/s_r_pld  in/out  ID_W+DATA_W+3+USER_W  {id,data,resp,last,user}

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Five identical FIFO instances, no cross-channel coupling. Per-FIFO rules, D = depth:
- Push when in_valid & in_ready; pop when out_valid & out_ready.
- in_ready = (count != D), registered; no same-cycle pop-to-ready path.
- out_valid = (count != 0); out payload = head entry.
- Latency: push at edge N gives out_valid high after edge N (1 cycle).
- Throughput: D=1 gives at most 1 beat per 2 cycles; D>=2 gives 1 beat/cycle sustained.
- Full: in_ready=0; a pop in that cycle frees a slot, and in_ready rises the next cycle.
- Empty: out_valid=0; payload don't-care.
- Simultaneous push and pop (0<count<D): count unchanged, order preserved.
- Pointers wrap from D-1 to 0 for any D, including non-power-of-2.
- count width = $clog2(D+1).
- Output stability: once out_valid=1, payload held unchanged until popped.
- D=0: out_valid=in_valid, in_ready=out_ready, payload wired straight through; no state.
- Reset (any cycle, including mid-burst): count and pointers go to 0, all *_valid outputs 0, all *_ready outputs 0 while rst=1. Ready outputs rise to 1 on the first cycle after rst deasserts. Buffered beats are discarded.
- No protocol checking; W beats are not associated with AW.

Optional Feature:
- AXI_SLICE_STATS_EN defined adds these outputs:
  - aw_lvl, w_lvl, b_lvl, ar_lvl, r_lvl: current counts, each $clog2(D+1) wide, 1-bit for D=0 and tied to 0
  - wr_outstanding[7:0]: +1 per s_aw handshake, −1 per s_b handshake; saturates at 255 and at 0; net 0 on same-cycle inc+dec; reset 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then W_DEPTH=4, m_w_ready=0; push 5 beats → first 4 accepted, s_w_ready=0 on 5th; m_w_valid=1 one cycle after the first push.
- Release m_w_ready=1 with continuous push → 1 beat/cycle, data order 0x0..0x7 exact, s_w_ready back high one cycle after the first pop.
- AW_DEPTH=1, always-ready sink, 10 back-to-back AWs → complete in 20 cycles, payload held stable while m_aw_ready=0.
- R_DEPTH=0 → m_r_ready follows s_r_ready combinationally; s_r_pld equals m_r_pld in the same cycle.
- Assert rst for 1 cycle with 3 B beats buffered → s_b_valid=0 next cycle, no stale beat after release, s_b_ready... m_b_ready=1 one cycle after rst low.
- With AXI_SLICE_STATS_EN: 3 AWs then 1 B → wr_outstanding=2; 300 AWs with no B → saturates at 255.

Source files
------------

// File: rtl/axi_chan_fifo_slice_if.sv
// AXI4+ATOP port bundle (AW/W/B/AR/R) with flattened payload vectors.
// master drives requests and B/R ready; slave drives the responses and AW/W/AR ready.
interface axi_chan_fifo_slice_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1
);
  localparam int STRB_W = DATA_W / 8;
  localparam int AW_W   = ID_W + ADDR_W + USER_W + 35;
  localparam int W_W    = DATA_W + STRB_W + 1 + USER_W;
  localparam int B_W    = ID_W + 2 + USER_W;
  localparam int AR_W   = ID_W + ADDR_W + USER_W + 29;
  localparam int R_W    = ID_W + DATA_W + 3 + USER_W;

  logic            aw_valid;
  logic            aw_ready;
  logic [AW_W-1:0] aw_pld;
  logic            w_valid;
  logic            w_ready;
  logic [W_W-1:0]  w_pld;
  logic            b_valid;
  logic            b_ready;
  logic [B_W-1:0]  b_pld;
  logic            ar_valid;
  logic            ar_ready;
  logic [AR_W-1:0] ar_pld;
  logic            r_valid;
  logic            r_ready;
  logic [R_W-1:0]  r_pld;

  modport master (
    output aw_valid, aw_pld, input aw_ready,
    output w_valid, w_pld, input w_ready,
    input b_valid, b_pld, output b_ready,
    output ar_valid, ar_pld, input ar_ready,
    input r_valid, r_pld, output r_ready
  );

  modport slave (
    input aw_valid, aw_pld, output aw_ready,
    input w_valid, w_pld, output w_ready,
    output b_valid, b_pld, input b_ready,
    input ar_valid, ar_pld, output ar_ready,
    output r_valid, r_pld, input r_ready
  );
endinterface

// File: rtl/axi_chan_fifo_slice.sv
// Per-channel AXI4+ATOP FIFO slice; depth 0 on a channel gives a combinational pass-through.
// Optional occupancy/outstanding-write statistics are built when AXI_SLICE_STATS_EN is defined.
module axi_chan_fifo_slice_fifo #(
  parameter int W = 8,
  parameter int D = 2,
  localparam int LW = (D == 0) ? 1 : $clog2(D + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pld,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pld
`ifdef AXI_SLICE_STATS_EN
  ,
  output logic [LW-1:0] lvl
`endif
);
  generate
    if (D == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst};
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign out_pld   = in_pld;
`ifdef AXI_SLICE_STATS_EN
      assign lvl = '0;
`endif
    end else begin : g_fifo
      localparam int PW    = (D > 1) ? $clog2(D) : 1;
      localparam int MEM_N = (D < 2) ? 2 : D;

      logic [W-1:0]  mem_reg [MEM_N];
      logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
      logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
      logic [LW-1:0] count_reg, count_next;
      logic          in_ready_reg;
      logic          push;
      logic          pop;

      assign in_ready  = in_ready_reg;
      assign out_valid = (count_reg != '0);
      assign out_pld   = mem_reg[rd_ptr_reg];
      assign push      = in_valid & in_ready_reg;
      assign pop       = out_valid & out_ready;
`ifdef AXI_SLICE_STATS_EN
      assign lvl = count_reg;
`endif

      // Explicit wrap so non-power-of-2 depths work.
      always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = (wr_ptr_reg == PW'(D - 1)) ? '0 : wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_next = (rd_ptr_reg == PW'(D - 1)) ? '0 : rd_ptr_reg + PW'(1);
        case ({push, pop})
          2'b10:   count_next = count_reg + LW'(1);
          2'b01:   count_next = count_reg - LW'(1);
          default: count_next = count_reg;
        endcase
      end

      // Ready is registered from the next count, so a pop in a full cycle shows up one cycle later.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          count_reg    <= '0;
          in_ready_reg <= 1'b0;
        end else begin
          wr_ptr_reg   <= wr_ptr_next;
          rd_ptr_reg   <= rd_ptr_next;
          count_reg    <= count_next;
          in_ready_reg <= (count_next != LW'(D));
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg] <= in_pld;
      end
    end
  endgenerate
endmodule

module axi_chan_fifo_slice #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int USER_W   = 1,
  parameter int AW_DEPTH = 2,
  parameter int W_DEPTH  = 4,
  parameter int B_DEPTH  = 2,
  parameter int AR_DEPTH = 2,
  parameter int R_DEPTH  = 4,
  localparam int AW_LW = (AW_DEPTH == 0) ? 1 : $clog2(AW_DEPTH + 1),
  localparam int W_LW  = (W_DEPTH == 0) ? 1 : $clog2(W_DEPTH + 1),
  localparam int B_LW  = (B_DEPTH == 0) ? 1 : $clog2(B_DEPTH + 1),
  localparam int AR_LW = (AR_DEPTH == 0) ? 1 : $clog2(AR_DEPTH + 1),
  localparam int R_LW  = (R_DEPTH == 0) ? 1 : $clog2(R_DEPTH + 1)
) (
  input logic                  clk,
  input logic                  rst,
  axi_chan_fifo_slice_if.slave  s_bus,
  axi_chan_fifo_slice_if.master m_bus
`ifdef AXI_SLICE_STATS_EN
  ,
  output logic [AW_LW-1:0] aw_lvl,
  output logic [W_LW-1:0]  w_lvl,
  output logic [B_LW-1:0]  b_lvl,
  output logic [AR_LW-1:0] ar_lvl,
  output logic [R_LW-1:0]  r_lvl,
  output logic [7:0]       wr_outstanding
`endif
);
  localparam int STRB_W = DATA_W / 8;
  localparam int AW_W   = ID_W + ADDR_W + USER_W + 35;
  localparam int W_W    = DATA_W + STRB_W + 1 + USER_W;
  localparam int B_W    = ID_W + 2 + USER_W;
  localparam int AR_W   = ID_W + ADDR_W + USER_W + 29;
  localparam int R_W    = ID_W + DATA_W + 3 + USER_W;

  axi_chan_fifo_slice_fifo #(.W(AW_W), .D(AW_DEPTH)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(s_bus.aw_valid), .in_ready(s_bus.aw_ready), .in_pld(s_bus.aw_pld),
    .out_valid(m_bus.aw_valid), .out_ready(m_bus.aw_ready), .out_pld(m_bus.aw_pld)
`ifdef AXI_SLICE_STATS_EN
    , .lvl(aw_lvl)
`endif
  );

  axi_chan_fifo_slice_fifo #(.W(W_W), .D(W_DEPTH)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(s_bus.w_valid), .in_ready(s_bus.w_ready), .in_pld(s_bus.w_pld),
    .out_valid(m_bus.w_valid), .out_ready(m_bus.w_ready), .out_pld(m_bus.w_pld)
`ifdef AXI_SLICE_STATS_EN
    , .lvl(w_lvl)
`endif
  );

  // Responses travel downstream-to-upstream.
  axi_chan_fifo_slice_fifo #(.W(B_W), .D(B_DEPTH)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(m_bus.b_valid), .in_ready(m_bus.b_ready), .in_pld(m_bus.b_pld),
    .out_valid(s_bus.b_valid), .out_ready(s_bus.b_ready), .out_pld(s_bus.b_pld)
`ifdef AXI_SLICE_STATS_EN
    , .lvl(b_lvl)
`endif
  );

  axi_chan_fifo_slice_fifo #(.W(AR_W), .D(AR_DEPTH)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(s_bus.ar_valid), .in_ready(s_bus.ar_ready), .in_pld(s_bus.ar_pld),
    .out_valid(m_bus.ar_valid), .out_ready(m_bus.ar_ready), .out_pld(m_bus.ar_pld)
`ifdef AXI_SLICE_STATS_EN
    , .lvl(ar_lvl)
`endif
  );

  axi_chan_fifo_slice_fifo #(.W(R_W), .D(R_DEPTH)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(m_bus.r_valid), .in_ready(m_bus.r_ready), .in_pld(m_bus.r_pld),
    .out_valid(s_bus.r_valid), .out_ready(s_bus.r_ready), .out_pld(s_bus.r_pld)
`ifdef AXI_SLICE_STATS_EN
    , .lvl(r_lvl)
`endif
  );

`ifdef AXI_SLICE_STATS_EN
  logic       wr_inc;
  logic       wr_dec;
  logic [7:0] wr_outstanding_reg;

  assign wr_inc         = s_bus.aw_valid & s_bus.aw_ready;
  assign wr_dec         = s_bus.b_valid & s_bus.b_ready;
  assign wr_outstanding = wr_outstanding_reg;

  // Saturating in both directions; a same-cycle inc and dec cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_outstanding_reg <= '0;
    end else if (wr_inc && !wr_dec && wr_outstanding_reg != 8'hFF) begin
      wr_outstanding_reg <= wr_outstanding_reg + 8'd1;
    end else if (wr_dec && !wr_inc && wr_outstanding_reg != 8'h00) begin
      wr_outstanding_reg <= wr_outstanding_reg - 8'd1;
    end
  end
`endif
endmodule
